// File: rtl/jtag_instr_data_regs.sv
// JTAG instruction register, BYPASS/IDCODE/USER data registers and TDO mux.
// All state advances on TCK rising edges qualified by the TAP state strobes.
module jtag_instr_data_regs #(
  parameter int unsigned IR_WIDTH   = 4,
  parameter int unsigned DR_WIDTH   = 16,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
  input  logic                i_tck,
  input  logic                i_trst,
  input  logic                i_tdi,
  input  logic                i_tlreset,
  input  logic                i_capture_dr,
  input  logic                i_shift_dr,
  input  logic                i_shift_ir,
  input  logic                i_update_dr,
  input  logic                i_update_ir,
  input  logic [DR_WIDTH-1:0] i_user_din,
  output logic                o_tdo,
  output logic [IR_WIDTH-1:0] o_instr,
  output logic [DR_WIDTH-1:0] o_user_dout,
  output logic                o_user_stb
);

  localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_USER_WR = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] OP_USER_RD = IR_WIDTH'(3);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0] r_ir_sr;
  logic                r_ir_active;
  logic [IR_WIDTH-1:0] r_instr;
  logic [31:0]         r_id_sr;
  logic [DR_WIDTH-1:0] r_user_sr;
  logic                r_bypass;
  logic [DR_WIDTH-1:0] r_user_dout;
  logic                r_user_stb;

  logic                w_sel_id;
  logic                w_sel_user_wr;
  logic                w_sel_user_rd;
  logic                w_sel_user;
  logic                w_sel_bypass;
  logic [DR_WIDTH-1:0] w_user_shifted;

  assign w_sel_id      = (r_instr == OP_IDCODE);
  assign w_sel_user_wr = (r_instr == OP_USER_WR);
  assign w_sel_user_rd = (r_instr == OP_USER_RD);
  assign w_sel_user    = w_sel_user_wr | w_sel_user_rd;
  assign w_sel_bypass  = ~(w_sel_id | w_sel_user);

  // A one-bit user register has no upper slice to shift down.
  if (DR_WIDTH > 1) begin : g_user_wide
    assign w_user_shifted = {i_tdi, r_user_sr[DR_WIDTH-1:1]};
  end else begin : g_user_bit
    assign w_user_shifted = i_tdi;
  end

  always_ff @(posedge i_tck) begin
    r_user_stb <= 1'b0;
    if (i_trst) begin
      r_ir_sr     <= IR_CAPTURE;
      r_ir_active <= 1'b0;
      r_instr     <= OP_IDCODE;
      r_id_sr     <= '0;
      r_user_sr   <= '0;
      r_bypass    <= 1'b0;
      r_user_dout <= '0;
    end else if (i_tlreset) begin
      r_ir_sr     <= IR_CAPTURE;
      r_ir_active <= 1'b0;
      r_instr     <= OP_IDCODE;
    end else begin
      if (i_update_ir) begin
        r_instr     <= r_ir_sr;
        r_ir_active <= 1'b0;
      end else if (i_shift_ir) begin
        r_ir_sr     <= {i_tdi, r_ir_sr[IR_WIDTH-1:1]};
        r_ir_active <= 1'b1;
      end else if (!r_ir_active) begin
        r_ir_sr <= IR_CAPTURE;
      end

      if (i_update_dr) begin
        if (w_sel_user_wr) begin
          r_user_dout <= r_user_sr;
          r_user_stb  <= 1'b1;
        end
      end else if (i_capture_dr) begin
        if (w_sel_id)      r_id_sr   <= IDCODE_VAL;
        if (w_sel_user_wr) r_user_sr <= r_user_dout;
        if (w_sel_user_rd) r_user_sr <= i_user_din;
        if (w_sel_bypass)  r_bypass  <= 1'b0;
      end else if (i_shift_dr) begin
        if (w_sel_id)     r_id_sr   <= {i_tdi, r_id_sr[31:1]};
        if (w_sel_user)   r_user_sr <= w_user_shifted;
        if (w_sel_bypass) r_bypass  <= i_tdi;
      end
    end
  end

  always_comb begin
    o_tdo = r_bypass;
    if (i_shift_ir)    o_tdo = r_ir_sr[0];
    else if (w_sel_id) o_tdo = r_id_sr[0];
    else if (w_sel_user) o_tdo = r_user_sr[0];
  end

  assign o_instr     = r_instr;
  assign o_user_dout = r_user_dout;
  assign o_user_stb  = r_user_stb;

endmodule
